// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs field-level instruction beats into the
// 16-bit datapath format and writes them to instruction memory from a base
// address, one write every two clocks.
module instr_encode_loader #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      baseAddr,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       inOpcode,
    input  logic [3:0]       inDr,
    input  logic [3:0]       inSr1,
    input  logic [3:0]       inSr2Imm,
    input  logic             inImmSel,
    input  logic [12:0]      inAddr,
    input  logic             inLast,
    output logic [15:0]      imemAddr,
    output logic [15:0]      imemData,
    output logic             imemWrite,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             fieldErr,
    output logic [CNT_W-1:0] wordCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [CNT_W:0] DEPTH_W = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0] ONE_W   = (CNT_W+1)'(1);

    state_t           state_q, state_d;
    logic [15:0]      ptr_q, ptr_d;
    logic [15:0]      lastAddr_q, lastAddr_d;
    logic [15:0]      word_q, word_d;
    logic             last_q, last_d;
    logic             overflow_q, overflow_d;
    logic             fieldErr_q, fieldErr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   countNext;
    logic [15:0]      enc;
    logic             badAddr;

    // Pack the incoming beat into the datapath instruction format.
    always_comb begin
        enc        = '0;
        enc[15:13] = inOpcode;
        case (inOpcode)
            3'b000: enc[12:0] = inAddr;
            3'b001, 3'b010, 3'b011: begin
                enc[12:9] = inDr;
                enc[8:5]  = inSr1;
                enc[4:1]  = inSr2Imm;
                enc[0]    = inImmSel;
            end
            3'b100, 3'b101: begin
                enc[12:9] = inDr;
                enc[8:0]  = inAddr[8:0];
            end
            default: enc[12:9] = inDr;
        endcase
        badAddr = ((inOpcode == 3'b100) || (inOpcode == 3'b101)) && (inAddr[12:9] != 4'b0000);
    end

    // Session sequencing: next state and register updates.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lastAddr_d = lastAddr_q;
        word_d     = word_q;
        last_d     = last_q;
        overflow_d = overflow_q;
        fieldErr_d = fieldErr_q;
        count_d    = count_q;
        countNext  = {1'b0, count_q} + ONE_W;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    fieldErr_d = 1'b0;
                    ptr_d      = baseAddr;
                    state_d    = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (inValid) begin
                    if (badAddr) begin
                        fieldErr_d = 1'b1;
                        state_d    = inLast ? S_DONE : S_ACCEPT;
                    end else begin
                        word_d  = enc;
                        last_d  = inLast;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ptr_d      = ptr_q + 16'd1;
                lastAddr_d = ptr_q;
                count_d    = countNext[CNT_W-1:0];
                if (last_q) begin
                    state_d = S_DONE;
                end else if (countNext == DEPTH_W) begin
                    overflow_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            lastAddr_q <= '0;
            word_q     <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            fieldErr_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lastAddr_q <= lastAddr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            fieldErr_q <= fieldErr_d;
            count_q    <= count_d;
        end
    end

    // Address shows the live pointer while writing, else the last written address.
    assign inReady   = (state_q == S_ACCEPT);
    assign imemWrite = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign imemAddr  = imemWrite ? ptr_q : lastAddr_q;
    assign imemData  = word_q;
    assign overflow  = overflow_q;
    assign fieldErr  = fieldErr_q;
    assign wordCount = count_q;

endmodule
